// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter (shift right, subtract-3 correction)
// Optional macro BCD_TO_BIN_DIGIT_CHECK_EN: reject operands holding a digit above 9 with err=1.
module bcd_to_bin #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [BCD_W-1:0]   bcd_reg;
   logic [BIN_W-1:0]   bin_reg;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   bcd_sh;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BIN_W-1:0]   bin_sh;
   logic               last_iter;
   logic               bad_digit;

   // One iteration: BCD LSB moves into the binary MSB, then halve-correct each digit.
   always_comb begin
      bcd_sh  = {1'b0, bcd_reg[BCD_W-1:1]};
      bin_sh  = {bcd_reg[0], bin_reg[BIN_W-1:1]};
      bcd_adj = bcd_sh;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_sh[4*i+3]) begin
            bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
         end
      end
   end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
   logic err_reg;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end

   assign err = err_reg;
`else
   assign bad_digit = 1'b0;
   assign err       = 1'b0;
`endif

   assign last_iter = (cnt == CNT_W'(BIN_W - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign bin_out   = bin_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = bad_digit ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_reg <= '0;
         bin_reg <= '0;
         cnt     <= '0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
         err_reg <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bcd_reg <= bad_digit ? '0 : bcd_in;
                  bin_reg <= '0;
                  cnt     <= '0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                  err_reg <= bad_digit;
`endif
               end
            end
            SHIFT: begin
               bcd_reg <= bcd_adj;
               bin_reg <= bin_sh;
               cnt     <= cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD input digits; legal range 1..6.
REQ-002 Parameter BIN_W, default 14: binary output width; SHALL equal ceil(log2(10^DIGITS)); 14 for DIGITS=4.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  bcd_in holds an operand.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0], most significant digit at the top.
REQ-008 out_valid  output  1  bin_out and err are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 bin_out  output  BIN_W  unsigned binary value of the accepted operand.
REQ-011 err  output  1  the accepted operand contained a digit greater than 9.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; the block SHALL have no other states.
REQ-013 in_ready SHALL be 1 only in IDLE; it SHALL be 0 in SHIFT and DONE.
REQ-014 Accept occurs on an edge with in_valid=1 and in_ready=1; this edge loads bcd_in into a DIGITS*4-bit BCD register, clears a BIN_W-bit binary register and an iteration counter, and moves to SHIFT.
REQ-015 in_valid while not in IDLE SHALL be ignored, and bcd_in changes after accept SHALL not affect the result.
REQ-016 Each SHIFT edge: shift {bcd_reg, bin_reg} right by 1 (bcd LSB enters bin MSB); then every 4-bit digit of the shifted bcd_reg that is >= 8 SHALL have 3 subtracted, modulo 16 within that digit.
REQ-017 SHIFT SHALL run exactly BIN_W iterations; the edge performing the last iteration moves to DONE and sets out_valid=1.
REQ-018 out_valid SHALL be observed high exactly BIN_W cycles after the accept edge (14 for default parameters).
REQ-019 In DONE, out_valid, bin_out and err SHALL hold stable until an edge with out_ready=1; that edge clears out_valid and returns the FSM to IDLE.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 A new operand SHALL NOT be accepted on the same edge that completes the output handshake; the earliest next accept is the following edge.
REQ-022 bin_out SHALL equal the decimal value of the operand for every all-valid operand, including 0 and 10^DIGITS-1.
REQ-023 Back-to-back throughput SHALL be one result per BIN_W+2 cycles when in_valid and out_ready are held at 1.

Reset
REQ-024 With rst=1 at an edge: FSM to IDLE; out_valid=0, err=0, bin_out=0, bcd_reg=0, counter=0; in_ready=1 from the next cycle.
REQ-025 Reset in SHIFT or DONE SHALL abort the operation; the pending result SHALL never be presented.
REQ-026 rst SHALL take priority over every handshake at the same edge.

Configuration
REQ-027 Macro BCD_TO_BIN_DIGIT_CHECK_EN enables input digit validation.
REQ-028 Defined: at the accept edge, if any digit > 9, the FSM SHALL go directly to DONE with bin_out=0, err=1, and out_valid observed high 1 cycle after accept; SHIFT is skipped.
REQ-029 Not defined: no validation is performed; err SHALL be tied to 0; an invalid digit runs the normal BIN_W-iteration sequence and bin_out is not specified.
REQ-030 The port list SHALL be identical with and without the macro.

Verification
REQ-031 bcd_in=16'h9999 accepted -> out_valid high 14 cycles later, bin_out=14'd9999 (0x270F), err=0.
REQ-032 bcd_in=16'h0000, then 16'h0001 -> bin_out=0, then 1; throughput 16 cycles per result with out_ready=1.
REQ-033 bcd_in=16'h1234, out_ready held 0 for 5 cycles after out_valid -> bin_out=1234 stable, in_ready=0 throughout; IDLE after out_ready=1.
REQ-034 in_valid=1 with bcd_in=16'h5555 during SHIFT of 16'h0042 -> result 42 only; 5555 not accepted.
REQ-035 rst=1 on the 7th SHIFT cycle of 16'h8765 -> out_valid=0, bin_out=0, in_ready=1 next cycle; no result appears.
REQ-036 Macro defined, bcd_in=16'h12A4 -> out_valid 1 cycle after accept, err=1, bin_out=0; macro undefined -> err stays 0.
